// File: rtl/cus19_store_buffer_if.sv
// Store-unit, data-memory and load-forwarding signals of the store buffer.
// The slave modport is the buffer; the master modport is the surrounding pipeline and memory.
interface cus19_store_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;

  modport slave (
    input  st_req, st_addr, st_data, mem_ack, ld_addr,
    output st_stall, mem_req, mem_addr, mem_data, ld_hit, ld_data, sb_empty, sb_count
  );

  modport master (
    output st_req, st_addr, st_data, mem_ack, ld_addr,
    input  st_stall, mem_req, mem_addr, mem_data, ld_hit, ld_data, sb_empty, sb_count
  );
endinterface

// File: rtl/cus19_store_buffer.sv
// Write-posting store buffer: circular FIFO of pending stores drained to data memory
// through req/ack, with youngest-match load forwarding.
module cus19_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cus19_store_buffer_if.slave   sb
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            entries [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  entry_t            head;
  logic [PTR_W-1:0]  fwd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // A full buffer refuses the push even when the head pops in the same cycle.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = sb.st_req & ~full;
  assign pop   = ~empty & sb.mem_ack;
  assign head  = entries[rd_ptr];

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: only entries inside the valid window are ever read out.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= '{addr: sb.st_addr, data: sb.st_data};
    end
  end

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entries[fwd_idx].addr == sb.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[fwd_idx].data;
      end
    end
  end

  assign sb.st_stall = sb.st_req & full;
  assign sb.mem_req  = ~empty;
  assign sb.mem_addr = empty ? '0 : head.addr;
  assign sb.mem_data = empty ? '0 : head.data;
  assign sb.ld_hit   = fwd_hit;
  assign sb.ld_data  = fwd_data;
  assign sb.sb_empty = empty;
  assign sb.sb_count = count;
endmodule

// File: tb/tb_cus19_store_buffer.sv
// Directed bench for cus19_store_buffer: hand-computed expectations checked with immediate
// assertions, plus a record of every write that data memory accepts.
module tb_cus19_store_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [18:0] writes [$];

  cus19_store_buffer_if #(.DEPTH(4), .ADDR_W(11), .DATA_W(8)) sbif ();

  cus19_store_buffer #(.DEPTH(4), .ADDR_W(11), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: record {addr,data} of each accepted write.
  always @(posedge clk) begin
    if (!rst && sbif.mem_req && sbif.mem_ack) writes.push_back({sbif.mem_addr, sbif.mem_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [10:0] a, input logic [7:0] d);
    logic [18:0] got;
    got = (idx < writes.size()) ? writes[idx] : 19'h7ffff;
    chk(tag, 32'(got), 32'({a, d}));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    sbif.st_req = 1'b0; sbif.st_addr = '0; sbif.st_data = '0;
    sbif.mem_ack = 1'b0; sbif.ld_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_empty", 32'(sbif.sb_empty), 32'd1);
    chk("rst_count", 32'(sbif.sb_count), 32'd0);
    chk("rst_mem_req", 32'(sbif.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(sbif.mem_addr), 32'd0);
    chk("rst_mem_data", 32'(sbif.mem_data), 32'd0);
    chk("rst_stall", 32'(sbif.st_stall), 32'd0);
    chk("rst_ld_hit", 32'(sbif.ld_hit), 32'd0);
    chk("rst_ld_data", 32'(sbif.ld_data), 32'd0);

    // Single store, held without ack, then popped
    sbif.st_req = 1'b1; sbif.st_addr = 11'h155; sbif.st_data = 8'hA5; sbif.ld_addr = 11'h155;
    #1;
    chk("single_no_stall", 32'(sbif.st_stall), 32'd0);
    chk("single_push_no_fwd", 32'(sbif.ld_hit), 32'd0);
    tick();
    sbif.st_req = 1'b0;
    #1;
    chk("single_mem_req", 32'(sbif.mem_req), 32'd1);
    chk("single_mem_addr", 32'(sbif.mem_addr), 32'h155);
    chk("single_mem_data", 32'(sbif.mem_data), 32'hA5);
    chk("single_count", 32'(sbif.sb_count), 32'd1);
    chk("single_fwd_data", 32'(sbif.ld_data), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold_req", 32'(sbif.mem_req), 32'd1);
      chk("single_hold_addr", 32'(sbif.mem_addr), 32'h155);
      chk("single_hold_data", 32'(sbif.mem_data), 32'hA5);
    end
    sbif.mem_ack = 1'b1;
    #1;
    chk("single_pop_still_fwd", 32'(sbif.ld_hit), 32'd1);
    tick();
    sbif.mem_ack = 1'b0;
    #1;
    chk("single_empty_after_pop", 32'(sbif.sb_empty), 32'd1);
    chk("single_mem_addr_zero", 32'(sbif.mem_addr), 32'd0);
    chk("single_write_count", 32'(writes.size()), 32'd1);
    chk_write("single_write", 0, 11'h155, 8'hA5);
    writes.delete();

    // Fill to full, stall, pop one, stalled store accepted next cycle
    for (int i = 1; i <= 4; i++) begin
      sbif.st_req = 1'b1; sbif.st_addr = 11'(i); sbif.st_data = 8'(8'h10 + i);
      #1;
      chk("fill_accept", 32'(sbif.st_stall), 32'd0);
      tick();
    end
    sbif.st_addr = 11'h005; sbif.st_data = 8'h15;
    #1;
    chk("full_stall", 32'(sbif.st_stall), 32'd1);
    chk("full_count", 32'(sbif.sb_count), 32'd4);
    sbif.mem_ack = 1'b1;
    #1;
    chk("full_pop_stall", 32'(sbif.st_stall), 32'd1);
    chk("full_head_addr", 32'(sbif.mem_addr), 32'h001);
    tick();
    sbif.mem_ack = 1'b0;
    #1;
    chk("after_pop_count", 32'(sbif.sb_count), 32'd3);
    chk("after_pop_no_stall", 32'(sbif.st_stall), 32'd0);
    tick();
    sbif.st_req = 1'b0;
    #1;
    chk("fifth_accepted", 32'(sbif.sb_count), 32'd4);
    sbif.mem_ack = 1'b1;
    repeat (4) tick();
    sbif.mem_ack = 1'b0;
    #1;
    chk("fill_drained", 32'(sbif.sb_empty), 32'd1);
    chk("fill_write_count", 32'(writes.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_write("fill_order", i, 11'(i + 1), 8'(8'h11 + i));
    writes.delete();

    // Forwarding picks the youngest match
    sbif.st_req = 1'b1;
    sbif.st_addr = 11'h0F0; sbif.st_data = 8'h11; tick();
    sbif.st_addr = 11'h0F1; sbif.st_data = 8'h22; tick();
    sbif.st_addr = 11'h0F0; sbif.st_data = 8'h33; tick();
    sbif.st_req = 1'b0;
    sbif.ld_addr = 11'h0F0;
    #1;
    chk("fwd_hit_f0", 32'(sbif.ld_hit), 32'd1);
    chk("fwd_youngest_f0", 32'(sbif.ld_data), 32'h33);
    sbif.ld_addr = 11'h0F1;
    #1;
    chk("fwd_data_f1", 32'(sbif.ld_data), 32'h22);
    sbif.ld_addr = 11'h0F2;
    #1;
    chk("fwd_miss_hit", 32'(sbif.ld_hit), 32'd0);
    chk("fwd_miss_data", 32'(sbif.ld_data), 32'd0);
    sbif.mem_ack = 1'b1;
    repeat (3) tick();
    sbif.mem_ack = 1'b0;
    #1;
    chk("fwd_drain_count", 32'(writes.size()), 32'd3);
    chk_write("fwd_drain_last", 2, 11'h0F0, 8'h33);
    writes.delete();

    // Streaming: push and pop every cycle, pointers wrap
    sbif.mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sbif.st_req = 1'b1; sbif.st_addr = 11'(11'h200 + i); sbif.st_data = 8'(i * 7);
      tick();
      chk("stream_count", 32'(sbif.sb_count), 32'd1);
    end
    sbif.st_req = 1'b0;
    tick();
    sbif.mem_ack = 1'b0;
    #1;
    chk("stream_empty", 32'(sbif.sb_empty), 32'd1);
    chk("stream_write_count", 32'(writes.size()), 32'd20);
    for (int i = 0; i < 20; i++) chk_write("stream_order", i, 11'(11'h200 + i), 8'(i * 7));
    writes.delete();

    // Reset with pending stores discards them
    sbif.st_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sbif.st_addr = 11'(11'h3A0 + i); sbif.st_data = 8'(8'hC0 + i);
      tick();
    end
    sbif.st_req = 1'b0;
    sbif.ld_addr = 11'h3A1;
    #1;
    chk("pre_rst_count", 32'(sbif.sb_count), 32'd3);
    chk("pre_rst_fwd", 32'(sbif.ld_data), 32'hC1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(sbif.sb_count), 32'd0);
    chk("mid_rst_mem_req", 32'(sbif.mem_req), 32'd0);
    chk("mid_rst_ld_hit", 32'(sbif.ld_hit), 32'd0);
    sbif.ld_addr = 11'h3A0;
    #1;
    chk("mid_rst_ld_hit_a0", 32'(sbif.ld_hit), 32'd0);
    sbif.mem_ack = 1'b1;
    repeat (3) tick();
    sbif.mem_ack = 1'b0;
    #1;
    chk("mid_rst_no_writes", 32'(writes.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
